alu_seq: RTL and testbench

- Parametrised, registered successor to the processor's single-cycle combinational ALU.
- Operand width is configurable. Inputs and outputs use a valid/ready handshake. The result is held in an output register until it is consumed.
- Outputs status flags (zero, carry, negative, overflow, error).
- Adds an optional multi-cycle shift-add multiplier.
- Sits between the register-file read stage and the writeback path.

---
 rtl/alu_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake on both sides.
// The result and flags sit in output registers until the consumer takes them.
// Optional macro ALU_SEQ_MUL_EN adds a WIDTH-step shift-add multiplier (opcode 8);
// without it, opcode 8 is reported as an invalid operation.
//
// Handshake: an operation is accepted on a rising edge where in_valid & in_ready;
// a result is consumed on a rising edge where out_valid & out_ready. in_ready is
// high only in IDLE, so a new operation cannot be accepted in the cycle its
// predecessor is consumed. in_valid outside IDLE and out_ready outside HOLD are ignored.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SEL_W-1:0] select,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             flag_err,
    output logic [1:0]       dbg_state
);

    localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_AND = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_XOR = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_SHL = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_SHR = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_CMP = SEL_W'(7);
`ifdef ALU_SEQ_MUL_EN
    localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(8);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_HOLD = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_HOLD = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic [WIDTH-1:0] alu_out_hi_q, alu_out_hi_d;
    logic             flag_z_q, flag_z_d;
    logic             flag_c_q, flag_c_d;
    logic             flag_n_q, flag_n_d;
    logic             flag_v_q, flag_v_d;
    logic             flag_err_q, flag_err_d;

    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_err;
    logic             accept;

`ifdef ALU_SEQ_MUL_EN
    // Product register: upper half accumulates, lower half starts as the
    // multiplier and is shifted out one bit per step.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     mul_upper;
    logic [2*WIDTH-1:0] mul_next;
    logic               op_is_mul;
`endif

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid & in_ready;

    // Single-cycle ALU result and flags for every non-multiply opcode.
    always_comb begin
        add_w   = {1'b0, in_a} + {1'b0, in_b};
        sub_w   = {1'b0, in_a} - {1'b0, in_b};
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        op_is_mul = 1'b0;
`endif
        case (select)
            OP_ADD: begin
                res   = add_w[WIDTH-1:0];
                res_c = add_w[WIDTH];
                res_v = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (add_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the widened difference is the borrow (a < b).
                res   = sub_w[WIDTH-1:0];
                res_c = sub_w[WIDTH];
                res_v = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (sub_w[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_AND: res = in_a & in_b;
            OP_OR:  res = in_a | in_b;
            OP_XOR: res = in_a ^ in_b;
            // Shift by the whole of in_b: amounts >= WIDTH shift everything out.
            OP_SHL: res = in_a << in_b;
            OP_SHR: res = in_a >> in_b;
            OP_CMP: begin
                if (in_a > in_b)      res = WIDTH'(1);
                else if (in_a < in_b) res = WIDTH'(2);
                else                  res = '0;
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: op_is_mul = 1'b1;
`endif
            default: res_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    always_comb begin
        mul_upper = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_upper, acc_q[WIDTH-1:1]};
    end
`endif

    // Next-state and next-output logic for the IDLE/MUL/HOLD controller.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        alu_out_d    = alu_out_q;
        alu_out_hi_d = alu_out_hi_q;
        flag_z_d     = flag_z_q;
        flag_c_d     = flag_c_q;
        flag_n_d     = flag_n_q;
        flag_v_d     = flag_v_q;
        flag_err_d   = flag_err_q;
`ifdef ALU_SEQ_MUL_EN
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_is_mul) begin
                        state_d = ST_MUL;
                        acc_d   = {{WIDTH{1'b0}}, in_b};
                        mcand_d = in_a;
                        cnt_d   = '0;
                    end else begin
`endif
                        state_d      = ST_HOLD;
                        out_valid_d  = 1'b1;
                        alu_out_d    = res;
                        alu_out_hi_d = '0;
                        flag_z_d     = (res == '0);
                        flag_c_d     = res_c;
                        flag_n_d     = res[WIDTH-1];
                        flag_v_d     = res_v;
                        flag_err_d   = res_err;
`ifdef ALU_SEQ_MUL_EN
                    end
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d      = ST_HOLD;
                    out_valid_d  = 1'b1;
                    alu_out_d    = mul_next[WIDTH-1:0];
                    alu_out_hi_d = mul_next[2*WIDTH-1:WIDTH];
                    flag_z_d     = (mul_next[WIDTH-1:0] == '0);
                    flag_c_d     = 1'b0;
                    flag_n_d     = mul_next[WIDTH-1];
                    flag_v_d     = 1'b0;
                    flag_err_d   = 1'b0;
                end
            end
`endif
            ST_HOLD: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            out_valid_q  <= 1'b0;
            alu_out_q    <= '0;
            alu_out_hi_q <= '0;
            flag_z_q     <= 1'b0;
            flag_c_q     <= 1'b0;
            flag_n_q     <= 1'b0;
            flag_v_q     <= 1'b0;
            flag_err_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_q        <= '0;
            mcand_q      <= '0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            alu_out_q    <= alu_out_d;
            alu_out_hi_q <= alu_out_hi_d;
            flag_z_q     <= flag_z_d;
            flag_c_q     <= flag_c_d;
            flag_n_q     <= flag_n_d;
            flag_v_q     <= flag_v_d;
            flag_err_q   <= flag_err_d;
`ifdef ALU_SEQ_MUL_EN
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_out    = alu_out_q;
    assign alu_out_hi = alu_out_hi_q;
    assign flag_z     = flag_z_q;
    assign flag_c     = flag_c_q;
    assign flag_n     = flag_n_q;
    assign flag_v     = flag_v_q;
    assign flag_err   = flag_err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=16). Expectations for opcode 8 follow
// the ALU_SEQ_MUL_EN setting the bench is compiled with.
module tb_alu_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   select;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic [W-1:0] alu_out_hi;
    logic         flag_z, flag_c, flag_n, flag_v, flag_err;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    int lat;

    alu_seq #(.WIDTH(W), .SEL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .select     (select),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_out    (alu_out),
        .alu_out_hi (alu_out_hi),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .flag_v     (flag_v),
        .flag_err   (flag_err),
        .dbg_state  (dbg_state)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, hold the result (out_ready=0) and return the
    // number of rising edges from the accept edge until out_valid is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] sel, output int latency);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        select    = sel;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        latency  = 1;
        while (!out_valid && latency < 100) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    // Take the held result.
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        select    = '0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (alu_out !== 16'h0000 || alu_out_hi !== 16'h0000) begin failures++; $display("FAIL reset_out got=%h_%h exp=0000_0000", alu_out_hi, alu_out); end
        checks++; if ({flag_z, flag_c, flag_n, flag_v, flag_err} !== 5'b00000) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {flag_z, flag_c, flag_n, flag_v, flag_err}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        run_op(16'hFFFF, 16'h0001, 4'd0, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL add_wrap_latency got=%0d exp=1", lat); end
        checks++; if (alu_out !== 16'h0000) begin failures++; $display("FAIL add_wrap_out got=%h exp=0000", alu_out); end
        checks++; if ({flag_z, flag_c, flag_n, flag_v, flag_err} !== 5'b11000) begin failures++; $display("FAIL add_wrap_flags zcnve got=%b exp=11000", {flag_z, flag_c, flag_n, flag_v, flag_err}); end
        consume();
        run_op(16'h7FFF, 16'h0001, 4'd0, lat);
        checks++; if (alu_out !== 16'h8000) begin failures++; $display("FAIL add_ovf_out got=%h exp=8000", alu_out); end
        checks++; if ({flag_z, flag_c, flag_n, flag_v, flag_err} !== 5'b00110) begin failures++; $display("FAIL add_ovf_flags zcnve got=%b exp=00110", {flag_z, flag_c, flag_n, flag_v, flag_err}); end
        consume();
    endtask

    task automatic test_sub_cmp();
        run_op(16'h0003, 16'h0005, 4'd1, lat);
        checks++; if (alu_out !== 16'hFFFE) begin failures++; $display("FAIL sub_out got=%h exp=fffe", alu_out); end
        checks++; if ({flag_z, flag_c, flag_n, flag_v, flag_err} !== 5'b01100) begin failures++; $display("FAIL sub_flags zcnve got=%b exp=01100", {flag_z, flag_c, flag_n, flag_v, flag_err}); end
        consume();
        run_op(16'h8000, 16'h0001, 4'd1, lat);
        checks++; if (alu_out !== 16'h7FFF || flag_v !== 1'b1 || flag_c !== 1'b0) begin failures++; $display("FAIL sub_ovf got=%h v=%b c=%b exp=7fff v=1 c=0", alu_out, flag_v, flag_c); end
        consume();
        run_op(16'd5, 16'd3, 4'd7, lat);
        checks++; if (alu_out !== 16'd1) begin failures++; $display("FAIL cmp_gt got=%0d exp=1", alu_out); end
        consume();
        run_op(16'd3, 16'd5, 4'd7, lat);
        checks++; if (alu_out !== 16'd2) begin failures++; $display("FAIL cmp_lt got=%0d exp=2", alu_out); end
        consume();
        run_op(16'd7, 16'd7, 4'd7, lat);
        checks++; if (alu_out !== 16'd0 || flag_z !== 1'b1) begin failures++; $display("FAIL cmp_eq got=%0d z=%b exp=0 z=1", alu_out, flag_z); end
        consume();
    endtask

    task automatic test_logic_shift();
        run_op(16'h00F0, 16'h0F00, 4'd3, lat);
        checks++; if (alu_out !== 16'h0FF0) begin failures++; $display("FAIL or_out got=%h exp=0ff0", alu_out); end
        consume();
        run_op(16'hFFFF, 16'h0F0F, 4'd4, lat);
        checks++; if (alu_out !== 16'hF0F0 || flag_n !== 1'b1) begin failures++; $display("FAIL xor_out got=%h n=%b exp=f0f0 n=1", alu_out, flag_n); end
        consume();
        run_op(16'h0001, 16'd4, 4'd5, lat);
        checks++; if (alu_out !== 16'h0010) begin failures++; $display("FAIL shl_4 got=%h exp=0010", alu_out); end
        consume();
        run_op(16'h8000, 16'd15, 4'd6, lat);
        checks++; if (alu_out !== 16'h0001) begin failures++; $display("FAIL shr_15 got=%h exp=0001", alu_out); end
        consume();
        run_op(16'h1234, 16'd16, 4'd5, lat);
        checks++; if (alu_out !== 16'h0000 || flag_z !== 1'b1) begin failures++; $display("FAIL shl_16 got=%h z=%b exp=0000 z=1", alu_out, flag_z); end
        consume();
    endtask

    task automatic test_backpressure();
        run_op(16'hF0F0, 16'hFF00, 4'd2, lat);
        checks++; if (alu_out !== 16'hF000 || flag_n !== 1'b1) begin failures++; $display("FAIL and_out got=%h n=%b exp=f000 n=1", alu_out, flag_n); end
        // Offer a competing operation while the result is held.
        @(negedge clk);
        in_a     = 16'h0001;
        in_b     = 16'h0001;
        select   = 4'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_out !== 16'hF000 || flag_n !== 1'b1 || flag_z !== 1'b0) begin
                failures++; $display("FAIL hold_stable cyc=%0d got valid=%b ready=%b out=%h n=%b z=%b exp valid=1 ready=0 out=f000 n=1 z=0", i, out_valid, in_ready, alu_out, flag_n, flag_z);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
        checks++; if (alu_out !== 16'hF000) begin failures++; $display("FAIL hold_ignored_op got=%h exp=f000", alu_out); end
        // out_ready while nothing is held must not produce anything.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL idle_out_ready got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready); end
    endtask

    task automatic test_mul();
        run_op(16'hFFFF, 16'hFFFF, 4'd8, lat);
`ifdef ALU_SEQ_MUL_EN
        checks++; if (lat !== 17) begin failures++; $display("FAIL mul_latency got=%0d exp=17", lat); end
        checks++; if (alu_out_hi !== 16'hFFFE || alu_out !== 16'h0001) begin failures++; $display("FAIL mul_max got=%h_%h exp=fffe_0001", alu_out_hi, alu_out); end
        checks++; if ({flag_z, flag_c, flag_n, flag_v, flag_err} !== 5'b00000) begin failures++; $display("FAIL mul_max_flags got=%b exp=00000", {flag_z, flag_c, flag_n, flag_v, flag_err}); end
        consume();
        run_op(16'h1234, 16'h0010, 4'd8, lat);
        checks++; if (alu_out_hi !== 16'h0001 || alu_out !== 16'h2340) begin failures++; $display("FAIL mul_small got=%h_%h exp=0001_2340", alu_out_hi, alu_out); end
`else
        checks++; if (lat !== 1) begin failures++; $display("FAIL mul_off_latency got=%0d exp=1", lat); end
        checks++; if (flag_err !== 1'b1 || alu_out !== 16'h0000 || alu_out_hi !== 16'h0000 || flag_z !== 1'b1) begin
            failures++; $display("FAIL mul_off got=%h_%h err=%b z=%b exp=0000_0000 err=1 z=1", alu_out_hi, alu_out, flag_err, flag_z);
        end
`endif
        consume();
        // The following ordinary op must clear the high half.
        run_op(16'h0002, 16'h0003, 4'd0, lat);
        checks++; if (alu_out !== 16'h0005 || alu_out_hi !== 16'h0000 || flag_err !== 1'b0) begin failures++; $display("FAIL after_mul got=%h_%h err=%b exp=0000_0005 err=0", alu_out_hi, alu_out, flag_err); end
        consume();
    endtask

    task automatic test_invalid();
        run_op(16'h1234, 16'h5678, 4'd12, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL inv_latency got=%0d exp=1", lat); end
        checks++; if (flag_err !== 1'b1 || flag_z !== 1'b1 || alu_out !== 16'h0000 || alu_out_hi !== 16'h0000) begin
            failures++; $display("FAIL inv_op got=%h_%h err=%b z=%b exp=0000_0000 err=1 z=1", alu_out_hi, alu_out, flag_err, flag_z);
        end
        consume();
    endtask

    task automatic test_reset_mid_hold();
        run_op(16'h7FFF, 16'h0001, 4'd0, lat);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || alu_out !== 16'h0000 || flag_n !== 1'b0 || flag_v !== 1'b0) begin
            failures++; $display("FAIL reset_hold got valid=%b out=%h n=%b v=%b exp valid=0 out=0000 n=0 v=0", out_valid, alu_out, flag_n, flag_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_idle got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_cmp();
        test_logic_shift();
        test_backpressure();
        test_mul();
        test_invalid();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
